// File: rtl/mem_pkg.sv
// Shared types, default parameters and width helpers for the multiport line memory.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    localparam int DEF_NUM_PORTS   = 2;
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_LINE_WORDS  = 4;
    localparam int DEF_DEPTH_WORDS = 2048;
    localparam int DEF_LATENCY     = 10;
    localparam int DEF_ADDR_W      = 32;

    // Byte-offset bits inside one line; these address bits are ignored.
    function automatic int line_off_w(input int word_w, input int line_words);
        return $clog2(line_words * word_w / 8);
    endfunction

    function automatic int line_idx_w(input int depth_words, input int line_words);
        return (depth_words / line_words < 2) ? 1 : $clog2(depth_words / line_words);
    endfunction

    // Counter only ever holds LATENCY-1 down to 0.
    function automatic int cnt_w(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/multiport_memory_if.sv
// Flattened per-port request/response bus; port p occupies slice p of every signal.
interface multiport_memory_if import mem_pkg::*; #(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LINE_W    = DEF_WORD_W * DEF_LINE_WORDS
);

    logic [NUM_PORTS-1:0]          req_valid;
    logic [NUM_PORTS-1:0]          req_ready;
    logic [NUM_PORTS-1:0]          req_write;
    logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
    logic [NUM_PORTS*LINE_W-1:0]   req_wdata;
    logic [NUM_PORTS*LINE_W/8-1:0] req_wstrb;
    logic [NUM_PORTS-1:0]          resp_valid;
    logic [NUM_PORTS-1:0]          resp_ready;
    logic [NUM_PORTS*LINE_W-1:0]   resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_port_ctrl.sv
// One requester port: request capture, fixed-latency countdown and response holding register.
module mem_port_ctrl import mem_pkg::*; #(
    parameter int LINE_W  = DEF_WORD_W * DEF_LINE_WORDS,
    parameter int IDX_W   = 9,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [IDX_W-1:0]    req_index_i,
    input  logic [LINE_W-1:0]   req_wdata_i,
    input  logic [LINE_W/8-1:0] req_wstrb_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [LINE_W-1:0]   resp_rdata_o,
    input  logic [LINE_W-1:0]   rd_line_i,
    output logic                access_fire_o,
    output logic                acc_write_o,
    output logic [IDX_W-1:0]    acc_index_o,
    output logic [LINE_W-1:0]   acc_wdata_o,
    output logic [LINE_W/8-1:0] acc_wstrb_o
);

    localparam int CW = cnt_w(LATENCY);

    mem_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W/8-1:0] wstrb_q, wstrb_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        index_d = index_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    index_d = req_index_i;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    // Array access happens on this edge; rd_line_i is the pre-write content.
                    rdata_d = write_q ? '0 : rd_line_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o   = (state_q == IDLE);
    assign resp_valid_o  = (state_q == RESP);
    assign resp_rdata_o  = rdata_q;
    assign access_fire_o = (state_q == BUSY) && (cnt_q == '0);
    assign acc_write_o   = write_q;
    assign acc_index_o   = index_q;
    assign acc_wdata_o   = wdata_q;
    assign acc_wstrb_o   = wstrb_q;

endmodule

// File: rtl/multiport_memory.sv
// Shared line-oriented word array with NUM_PORTS independent fixed-latency ports and
// per-byte lowest-port-wins write merging.
module multiport_memory import mem_pkg::*; #(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    multiport_memory_if.slave  bus
);

    localparam int LINE_W = WORD_W * LINE_WORDS;
    localparam int STRB_W = LINE_W / 8;
    localparam int BPW    = WORD_W / 8;
    localparam int OFF_W  = line_off_w(WORD_W, LINE_WORDS);
    localparam int IDX_W  = line_idx_w(DEPTH_WORDS, LINE_WORDS);
    localparam int WIDX_W = $clog2(DEPTH_WORDS);

    // NOTE: the word array is deliberately not reset; its contents survive reset_n.
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic [NUM_PORTS-1:0] access_fire;
    logic [NUM_PORTS-1:0] acc_write;
    logic [IDX_W-1:0]     acc_index [NUM_PORTS];
    logic [LINE_W-1:0]    acc_wdata [NUM_PORTS];
    logic [STRB_W-1:0]    acc_wstrb [NUM_PORTS];
    logic [LINE_W-1:0]    rd_line   [NUM_PORTS];
    logic                 unused_addr;

    function automatic logic [WIDX_W-1:0] word_addr(input logic [IDX_W-1:0] idx, input int w);
        return WIDX_W'(idx) * WIDX_W'(LINE_WORDS) + WIDX_W'(w);
    endfunction

    // Offset and upper address bits are intentionally dropped (alignment and wrap).
    assign unused_addr = ^bus.req_addr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mem_port_ctrl #(
            .LINE_W  (LINE_W),
            .IDX_W   (IDX_W),
            .LATENCY (LATENCY)
        ) u_ctrl (
            .clk           (clk),
            .reset_n       (reset_n),
            .req_valid_i   (bus.req_valid[p]),
            .req_ready_o   (bus.req_ready[p]),
            .req_write_i   (bus.req_write[p]),
            .req_index_i   (bus.req_addr[p*ADDR_W + OFF_W +: IDX_W]),
            .req_wdata_i   (bus.req_wdata[p*LINE_W +: LINE_W]),
            .req_wstrb_i   (bus.req_wstrb[p*STRB_W +: STRB_W]),
            .resp_valid_o  (bus.resp_valid[p]),
            .resp_ready_i  (bus.resp_ready[p]),
            .resp_rdata_o  (bus.resp_rdata[p*LINE_W +: LINE_W]),
            .rd_line_i     (rd_line[p]),
            .access_fire_o (access_fire[p]),
            .acc_write_o   (acc_write[p]),
            .acc_index_o   (acc_index[p]),
            .acc_wdata_o   (acc_wdata[p]),
            .acc_wstrb_o   (acc_wstrb[p])
        );
    end

    always_comb begin
        rd_line = '{default: '0};
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                rd_line[p][w*WORD_W +: WORD_W] = mem_q[word_addr(acc_index[p], w)];
            end
        end
    end

    // Highest port is applied first so the lowest-numbered port's byte lands last and wins.
    always_ff @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (access_fire[p] && acc_write[p]) begin
                for (int w = 0; w < LINE_WORDS; w++) begin
                    for (int b = 0; b < BPW; b++) begin
                        if (acc_wstrb[p][w*BPW + b]) begin
                            mem_q[word_addr(acc_index[p], w)][b*8 +: 8] <=
                                acc_wdata[p][(w*BPW + b)*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_memory.sv
// Scoreboard bench for multiport_memory: expected lines queued per port at request time.
module tb_multiport_memory;

    localparam int NP     = 3;
    localparam int WORD_W = 32;
    localparam int LW     = 4;
    localparam int DEPTH  = 2048;
    localparam int LAT    = 10;
    localparam int AW     = 32;
    localparam int LINE_W = WORD_W * LW;
    localparam int STRB_W = LINE_W / 8;
    localparam int NLINES = DEPTH / LW;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [STRB_W-1:0] strb_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    line_t             exp_q [NP][$];
    logic [WORD_W-1:0] model [DEPTH];

    always #5 clk = ~clk;

    multiport_memory_if #(.NUM_PORTS(NP), .ADDR_W(AW), .LINE_W(LINE_W)) bus ();

    multiport_memory #(
        .NUM_PORTS   (NP),
        .WORD_W      (WORD_W),
        .LINE_WORDS  (LW),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .ADDR_W      (AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int line_of(input logic [AW-1:0] a);
        return int'((a / 16) % NLINES);
    endfunction

    function automatic line_t model_line(input int idx);
        line_t l;
        for (int w = 0; w < LW; w++) l[w*WORD_W +: WORD_W] = model[idx*LW + w];
        return l;
    endfunction

    task automatic model_write(input int idx, input line_t d, input strb_t s);
        for (int w = 0; w < LW; w++)
            for (int b = 0; b < 4; b++)
                if (s[w*4 + b]) model[idx*LW + w][b*8 +: 8] = d[(w*4 + b)*8 +: 8];
    endtask

    // Presents a request, waits for acceptance and queues the expected response line.
    task automatic issue(input int p, input bit wr, input logic [AW-1:0] a, input line_t d, input strb_t s);
        int n = 0;
        bus.req_write[p] = wr;
        bus.req_addr[p*AW +: AW] = a;
        bus.req_wdata[p*LINE_W +: LINE_W] = d;
        bus.req_wstrb[p*STRB_W +: STRB_W] = s;
        bus.req_valid[p] = 1'b1;
        while (!bus.req_ready[p] && n < 200) begin
            step();
            n++;
        end
        if (!bus.req_ready[p]) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout port=%0d req_ready stayed 0", p);
        end
        exp_q[p].push_back(wr ? line_t'(0) : model_line(line_of(a)));
        step();
        bus.req_valid[p] = 1'b0;
    endtask

    // Waits (bounded) for resp_valid; completes the handshake if resp_ready is high.
    task automatic await_resp(input int p, input int max, output line_t got, output bit ok);
        int n = 0;
        while (!bus.resp_valid[p] && n < max) begin
            step();
            n++;
        end
        ok  = bus.resp_valid[p];
        got = bus.resp_rdata[p*LINE_W +: LINE_W];
        if (ok && bus.resp_ready[p]) step();
    endtask

    task automatic test_reset();
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0; bus.resp_ready = '1;
        step(2);
        checks++;
        if (bus.req_ready !== '1 || bus.resp_valid !== '0 || bus.resp_rdata !== '0) begin
            failures++;
            $display("FAIL reset_values req_ready=%b resp_valid=%b rdata_nonzero=%0b",
                     bus.req_ready, bus.resp_valid, |bus.resp_rdata);
        end
        bus.req_valid[0] = 1'b1;
        step(2);
        reset_n = 1'b1;
        bus.req_valid[0] = 1'b0;
        step();
        checks++;
        if (bus.req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_no_accept req_ready=%b required 1", bus.req_ready[0]);
        end
    endtask

    task automatic test_read_latency();
        line_t exp;
        issue(0, 1'b0, 32'h0, '0, '0);
        checks++;
        if (bus.req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL lat_ready_c0 req_ready=%b required 0", bus.req_ready[0]);
        end
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) step();
            else step();
            checks++;
            if ({bus.resp_valid[0], bus.req_ready[0]} !== {k == LAT, 1'b0}) begin
                failures++;
                $display("FAIL lat_cycle%0d valid/ready=%b%b required %b0", k,
                         bus.resp_valid[0], bus.req_ready[0], k == LAT);
            end
        end
        exp = exp_q[0].pop_front();
        checks++;
        if (bus.resp_rdata[0 +: LINE_W] !== exp || exp !== '0) begin
            failures++;
            $display("FAIL lat_rdata got=%h required=0", bus.resp_rdata[0 +: LINE_W]);
        end
        step();
        checks++;
        if ({bus.resp_valid[0], bus.req_ready[0]} !== 2'b01) begin
            failures++;
            $display("FAIL lat_ready_return valid/ready=%b%b required 01",
                     bus.resp_valid[0], bus.req_ready[0]);
        end
    endtask

    task automatic test_write_offset();
        line_t d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        logic [AW-1:0] addrs [3] = '{32'h40, 32'h4C, 32'h2040};
        line_t got, exp;
        bit ok;
        issue(1, 1'b1, 32'h40, d, '1);
        model_write(line_of(32'h40), d, '1);
        await_resp(1, 50, got, ok);
        exp = exp_q[1].pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL wr_ack ok=%0b got=%h required=%h", ok, got, exp);
        end
        for (int i = 1; i < 3; i++) begin
            issue(1, 1'b0, addrs[i], '0, '0);
            await_resp(1, 50, got, ok);
            exp = exp_q[1].pop_front();
            checks++;
            if (!ok || got !== exp || got !== d) begin
                failures++;
                $display("FAIL rd_offset addr=%h ok=%0b got=%h required=%h", addrs[i], ok, got, d);
            end
        end
    endtask

    task automatic test_strobe();
        line_t d = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF};
        line_t want = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
        strb_t strbs [2] = '{16'h000F, 16'h0000};
        line_t got, exp;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            issue(1, 1'b1, 32'h40, i == 0 ? d : line_t'(0), strbs[i]);
            model_write(line_of(32'h40), i == 0 ? d : line_t'(0), strbs[i]);
            await_resp(1, 50, got, ok);
            exp = exp_q[1].pop_front();
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL strb_ack%0d ok=%0b got=%h required=%h", i, ok, got, exp);
            end
            issue(1, 1'b0, 32'h40, '0, '0);
            await_resp(1, 50, got, ok);
            exp = exp_q[1].pop_front();
            checks++;
            if (!ok || got !== exp || got !== want) begin
                failures++;
                $display("FAIL strb_read%0d got=%h required=%h", i, got, want);
            end
        end
    endtask

    task automatic test_same_edge();
        line_t a5 = {4{32'h55555555}};
        line_t aa = {4{32'hAAAAAAAA}};
        line_t got, exp, want;
        bit ok;
        for (int it = 0; it < 2; it++) begin
            logic [AW-1:0] a = (it == 0) ? 32'h80 : 32'hC0;
            strb_t s0 = (it == 0) ? 16'hFFFF : 16'h0F0F;
            want = (it == 0) ? aa : {32'h55555555, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA};
            bus.resp_ready = 3'b001;
            bus.req_write = 3'b011;
            for (int p = 0; p < NP; p++) bus.req_addr[p*AW +: AW] = a;
            bus.req_wdata[0 +: LINE_W] = aa;
            bus.req_wdata[LINE_W +: LINE_W] = a5;
            bus.req_wstrb[0 +: STRB_W] = s0;
            bus.req_wstrb[STRB_W +: STRB_W] = '1;
            exp_q[0].push_back('0);
            exp_q[1].push_back('0);
            exp_q[2].push_back(model_line(line_of(a)));
            bus.req_valid = '1;
            step();
            bus.req_valid = '0;
            model_write(line_of(a), a5, '1);
            model_write(line_of(a), aa, s0);
            for (int p = 0; p < NP; p++) begin
                bus.resp_ready[p] = 1'b1;
                await_resp(p, 50, got, ok);
                exp = exp_q[p].pop_front();
                checks++;
                if (!ok || got !== exp) begin
                    failures++;
                    $display("FAIL same_edge_resp%0d port=%0d ok=%0b got=%h required=%h", it, p, ok, got, exp);
                end
            end
            issue(2, 1'b0, a, '0, '0);
            await_resp(2, 50, got, ok);
            exp = exp_q[2].pop_front();
            checks++;
            if (!ok || got !== exp || got !== want) begin
                failures++;
                $display("FAIL same_edge_merge%0d got=%h required=%h", it, got, want);
            end
        end
    endtask

    task automatic test_backpressure();
        line_t got, held, exp;
        bit ok;
        bus.resp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h40, '0, '0);
        await_resp(0, 50, held, ok);
        exp = exp_q[0].pop_front();
        checks++;
        if (!ok || held !== exp) begin
            failures++;
            $display("FAIL bp_first ok=%0b got=%h required=%h", ok, held, exp);
        end
        bus.req_write[0] = 1'b0;
        bus.req_addr[0 +: AW] = 32'h80;
        bus.req_valid[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (bus.resp_valid[0] !== 1'b1 || bus.req_ready[0] !== 1'b0 ||
                bus.resp_rdata[0 +: LINE_W] !== held) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b ready=%b rdata=%h required 1/0/%h", i,
                         bus.resp_valid[0], bus.req_ready[0], bus.resp_rdata[0 +: LINE_W], held);
            end
        end
        bus.resp_ready[0] = 1'b1;
        step();
        checks++;
        if ({bus.resp_valid[0], bus.req_ready[0]} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release valid/ready=%b%b required 01", bus.resp_valid[0], bus.req_ready[0]);
        end
        exp_q[0].push_back(model_line(line_of(32'h80)));
        step();
        bus.req_valid[0] = 1'b0;
        await_resp(0, 50, got, ok);
        exp = exp_q[0].pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL bp_second ok=%0b got=%h required=%h", ok, got, exp);
        end
    endtask

    task automatic test_reset_mid_write();
        line_t la = {32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D};
        line_t lb = {4{32'hF00DF00D}};
        line_t got, exp;
        bit ok;
        bus.resp_ready = '1;
        issue(1, 1'b1, 32'h100, la, '1);
        model_write(line_of(32'h100), la, '1);
        await_resp(1, 50, got, ok);
        exp = exp_q[1].pop_front();
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL rst_pre_ack ok=%0b got=%h required=%h", ok, got, exp);
        end
        issue(1, 1'b1, 32'h100, lb, '1);
        void'(exp_q[1].pop_back());
        step(4);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== '0 || bus.req_ready !== '1 || bus.resp_rdata !== '0) begin
            failures++;
            $display("FAIL rst_async valid=%b ready=%b rdata_nonzero=%0b required 000/111/0",
                     bus.resp_valid, bus.req_ready, |bus.resp_rdata);
        end
        step(2);
        reset_n = 1'b1;
        step(LAT + 2);
        checks++;
        if (bus.resp_valid !== '0 || bus.req_ready !== '1) begin
            failures++;
            $display("FAIL rst_after valid=%b ready=%b required 000/111", bus.resp_valid, bus.req_ready);
        end
        issue(1, 1'b0, 32'h100, '0, '0);
        await_resp(1, 50, got, ok);
        exp = exp_q[1].pop_front();
        checks++;
        if (!ok || got !== exp || got !== la) begin
            failures++;
            $display("FAIL rst_old_data got=%h required=%h", got, la);
        end
    endtask

    task automatic test_back_to_back();
        line_t got, exp, d;
        bit ok;
        logic [AW-1:0] a;
        strb_t s;
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom_range(0, 32'h3FFF));
            d = {$urandom, $urandom, $urandom, $urandom};
            s = strb_t'($urandom);
            issue(1, 1'b1, a, d, s);
            model_write(line_of(a), d, s);
            await_resp(1, 50, got, ok);
            exp = exp_q[1].pop_front();
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL b2b_ack%0d ok=%0b got=%h required=%h", i, ok, got, exp);
            end
            issue(0, 1'b0, a ^ 32'h2000, '0, '0);
            await_resp(0, 50, got, ok);
            exp = exp_q[0].pop_front();
            checks++;
            if (!ok || got !== exp) begin
                failures++;
                $display("FAIL b2b_read%0d addr=%h got=%h required=%h", i, a, got, exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_read_latency();
        test_write_offset();
        test_strobe();
        test_same_edge();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
